keyed_nco_tx: RTL



---
 rtl/keyed_tx_pkg.sv | 25 ++
 rtl/key_debounce.sv | 45 ++++
 rtl/keyed_nco_tx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/keyed_tx_pkg.sv
// Shared types and board-level defaults for the keyed NCO transmitter.
// Default cycle counts assume the 27 MHz Tang board clock.
package keyed_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEYED = 2'd1,
    HANG  = 2'd2,
    DRAIN = 2'd3
  } tx_state_e;

  localparam int unsigned CLK_HZ      = 27_000_000;
  localparam int unsigned DEBOUNCE_MS = 10;
  localparam int unsigned HANG_MS     = 100;

  localparam int unsigned DEF_DEBOUNCE_CYC = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned DEF_HANG_CYC     = (CLK_HZ / 1000) * HANG_MS;
  localparam int unsigned DEF_BLINK_HALF   = 8_388_608;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stability counter for a raw board key.
// The accepted level only flips after DEBOUNCE_CYC consecutive differing samples.
module key_debounce
  import keyed_tx_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter logic        RESET_LEVEL  = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_level
);

  localparam int unsigned     CW       = cnt_w(DEBOUNCE_CYC);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= RESET_LEVEL;
      r_sync2 <= RESET_LEVEL;
      r_level <= RESET_LEVEL;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/keyed_nco_tx.sv
// Keyed NCO square-wave transmitter: debounced key gates a phase-accumulator
// carrier with hang time, runt-free drain, shadowed retuning and a status blinker.
module keyed_nco_tx
  import keyed_tx_pkg::*;
#(
  parameter int unsigned       ACC_W        = 32,
  parameter logic [ACC_W-1:0]  RESET_TUNE   = {1'b1, {(ACC_W-1){1'b0}}},
  parameter int unsigned       DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned       HANG_CYC     = DEF_HANG_CYC,
  parameter int unsigned       BLINK_HALF   = DEF_BLINK_HALF
) (
  input  logic             clk_27MHz,
  input  logic             rst,
  input  logic             key,
  input  logic [ACC_W-1:0] tune_word,
  input  logic             tune_load,
  output logic             tx_out,
  output logic             tx_active,
  output logic             key_led,
  output logic             status_led
);

  localparam int unsigned   HW         = cnt_w(HANG_CYC);
  localparam logic [HW-1:0] HANG_LAST  = HW'(HANG_CYC - 1);
  localparam int unsigned   BW         = cnt_w(BLINK_HALF);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic             w_key_level;
  logic             w_pressed;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic             w_apply;

  tx_state_e        r_state;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_tune;
  logic [ACC_W-1:0] r_pend;
  logic             r_pend_v;
  logic [HW-1:0]    r_hang_cnt;
  logic [BW-1:0]    r_blink_cnt;
  logic             r_tx_out;
  logic             r_tx_active;
  logic             r_status;

  key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .RESET_LEVEL  (1'b1)
  ) u_key_debounce (
    .i_clk   (clk_27MHz),
    .i_rst   (rst),
    .i_key   (key),
    .o_level (w_key_level)
  );

  assign w_pressed = ~w_key_level;

  // Retuning only lands on a carry-out so the running period always completes.
  assign w_sum   = {1'b0, r_acc} + {1'b0, r_tune};
  assign w_carry = (r_state != IDLE) && w_sum[ACC_W];
  assign w_apply = r_pend_v && ((r_state == IDLE) || w_carry);

  always_ff @(posedge clk_27MHz) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_hang_cnt  <= '0;
      r_tx_out    <= 1'b0;
      r_tx_active <= 1'b0;
    end else begin
      r_acc    <= (r_state == IDLE) ? '0 : w_sum[ACC_W-1:0];
      r_tx_out <= (r_state == IDLE) ? 1'b0 : w_sum[ACC_W-1];
      case (r_state)
        IDLE: begin
          if (w_pressed) begin
            r_state     <= KEYED;
            r_tx_active <= 1'b1;
          end
        end
        KEYED: begin
          if (!w_pressed) begin
            r_state    <= HANG;
            r_hang_cnt <= '0;
          end
        end
        HANG: begin
          if (w_pressed) begin
            r_state <= KEYED;
          end else if (r_hang_cnt == HANG_LAST) begin
            r_state <= DRAIN;
          end else begin
            r_hang_cnt <= r_hang_cnt + 1'b1;
          end
        end
        DRAIN: begin
          // Leave only once the next phase is in the low half: no truncated high pulse.
          if (w_pressed) begin
            r_state <= KEYED;
          end else if (!w_sum[ACC_W-1]) begin
            r_state     <= IDLE;
            r_tx_active <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_27MHz) begin
    if (rst) begin
      r_tune   <= RESET_TUNE;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
    end else begin
      if (w_apply) begin
        r_tune <= r_pend;
      end
      if (tune_load) begin
        r_pend   <= tune_word;
        r_pend_v <= 1'b1;
      end else if (w_apply) begin
        r_pend_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_27MHz) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_status    <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_status    <= ~r_status;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign tx_out     = r_tx_out;
  assign tx_active  = r_tx_active;
  assign key_led    = w_key_level;
  assign status_led = r_status;

endmodule
